// File: rtl/mul_div_pkg.sv
// mul_div_pkg: op encodings and FSM states shared by the multiply/divide unit
package mul_div_pkg;
  localparam logic [1:0] OP_MULS = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIVS = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/mul_div_if.sv
// mul_div_if: start/done request bus between the sequencer and the multiply/divide unit
interface mul_div_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  modport master(output start, op, a, b, input busy, done, hi, lo, div_by_zero);
  modport slave(input start, op, a, b, output busy, done, hi, lo, div_by_zero);
endinterface

// File: rtl/mul_div_sign.sv
// mul_div_sign: conditional negate of a hi/lo pair, either as two halves or as one 2*WIDTH value
module mul_div_sign #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic             i_neg_hi,
  input  logic             i_neg_lo,
  input  logic             i_wide,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic [2*WIDTH-1:0] w_n;
  assign w_n  = -{i_hi, i_lo};
  assign o_hi = !i_neg_hi ? i_hi : i_wide ? w_n[2*WIDTH-1:WIDTH] : -i_hi;
  assign o_lo = !i_neg_lo ? i_lo : i_wide ? w_n[WIDTH-1:0] : -i_lo;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed/unsigned shift-add multiplier and restoring divider
module mul_div_unit import mul_div_pkg::*; #(parameter int WIDTH = 32) (
  input logic      clock,
  input logic      clear,
  mul_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t             r_state, w_state_n;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_acc, w_mul, w_div;
  logic [WIDTH-1:0]   r_b, r_hi, r_lo, w_ma, w_mb, w_rh, w_rl, w_sub;
  logic [WIDTH:0]     w_sum, w_shr;
  logic r_busy, r_done, r_dz, r_isdz, r_div, r_wide, r_neg_hi, r_neg_lo;
  logic w_signed, w_isdiv, w_na, w_nb, w_dz0, w_ge, w_fin;
  assign w_signed = bus.op == OP_MULS || bus.op == OP_DIVS;
  assign w_isdiv  = bus.op == OP_DIVS || bus.op == OP_DIVU;
  assign w_na     = w_signed & bus.a[WIDTH-1];
  assign w_nb     = w_signed & bus.b[WIDTH-1];
  assign w_dz0    = w_isdiv && bus.b == '0;
  mul_div_sign #(.WIDTH(WIDTH)) u_prep (
    .i_hi(bus.a), .i_lo(bus.b), .i_neg_hi(w_na), .i_neg_lo(w_nb), .i_wide(1'b0),
    .o_hi(w_ma), .o_lo(w_mb)
  );
  mul_div_sign #(.WIDTH(WIDTH)) u_fix (
    .i_hi(r_acc[2*WIDTH-1:WIDTH]), .i_lo(r_acc[WIDTH-1:0]), .i_neg_hi(r_neg_hi),
    .i_neg_lo(r_neg_lo), .i_wide(r_wide), .o_hi(w_rh), .o_lo(w_rl)
  );
  // multiply: acc = {partial, multiplier}; add on lsb, then shift right with carry
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul = {w_sum, r_acc[WIDTH-1:1]};
  // divide: acc = {remainder, dividend/quotient}; trial subtract after left shift
  assign w_shr = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge  = w_shr >= {1'b0, r_b};
  assign w_sub = w_shr[WIDTH-1:0] - r_b;
  assign w_div = {w_ge ? w_sub : w_shr[WIDTH-1:0], r_acc[WIDTH-2:0], w_ge};
  assign w_fin = r_state == FIX && r_count == '0;
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    w_state_n = bus.start ? (w_dz0 ? FIX : CALC) : IDLE;
      CALC:    w_state_n = r_count == '0 ? FIX : CALC;
      FIX:     w_state_n = r_count == '0 ? IDLE : FIX;
      default: w_state_n = IDLE;
    endcase
  end
  // divide-by-zero parks in FIX with count=1 so done lands two edges after start
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_isdz   <= 1'b0;
      r_div    <= 1'b0;
      r_wide   <= 1'b0;
      r_neg_hi <= 1'b0;
      r_neg_lo <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_busy  <= w_state_n != IDLE;
      r_done  <= w_fin;
      if (r_state == IDLE && bus.start) begin
        r_div    <= w_isdiv;
        r_wide   <= !w_isdiv;
        r_isdz   <= w_dz0;
        r_b      <= w_mb;
        r_neg_hi <= !w_dz0 && (w_isdiv ? w_na : w_na ^ w_nb);
        r_neg_lo <= !w_dz0 && (w_na ^ w_nb);
        r_acc    <= w_dz0 ? {bus.a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, w_ma};
        r_count  <= w_dz0 ? CW'(1) : CW'(WIDTH - 1);
      end
      if (r_state == CALC) r_acc <= r_div ? w_div : w_mul;
      if (r_state != IDLE && r_count != '0) r_count <= r_count - 1'b1;
      if (w_fin) begin
        r_hi <= w_rh;
        r_lo <= w_rl;
        r_dz <= r_isdz;
      end
    end
  end
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.div_by_zero = r_dz;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random checks of mul_div_unit at WIDTH=32 and WIDTH=8
module tb_mul_div_unit;
  import mul_div_pkg::*;
  logic clk = 1'b0;
  logic clear;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mul_div_if #(.WIDTH(32)) s32 ();
  mul_div_if #(.WIDTH(8))  s8 ();
  mul_div_unit #(.WIDTH(32)) dut32 (.clock(clk), .clear(clear), .bus(s32));
  mul_div_unit #(.WIDTH(8))  dut8  (.clock(clk), .clear(clear), .bus(s8));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic void ref32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    logic [63:0] p;
    z = 1'b0;
    if (o == OP_MULS) p = 64'(sx * sy);
    else if (o == OP_MULU) p = {32'b0, x} * {32'b0, y};
    else if (y == 32'h0) begin p = {x, 32'hFFFFFFFF}; z = 1'b1; end
    else if (o == OP_DIVS) p = {32'(sx % sy), 32'(sx / sy)};
    else p = {x % y, x / y};
    h = p[63:32];
    l = p[31:0];
  endfunction
  function automatic void ref8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                               output logic [7:0] h, output logic [7:0] l, output logic z);
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    logic [15:0] p;
    z = 1'b0;
    if (o == OP_MULS) p = 16'(sx * sy);
    else if (o == OP_MULU) p = {8'b0, x} * {8'b0, y};
    else if (y == 8'h0) begin p = {x, 8'hFF}; z = 1'b1; end
    else if (o == OP_DIVS) p = {8'(sx % sy), 8'(sx / sy)};
    else p = {x % y, x / y};
    h = p[15:8];
    l = p[7:0];
  endfunction
  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string tag, input bit inject = 1'b0);
    logic [31:0] eh, el, ph, pl;
    logic ez;
    int n, lat;
    ref32(o, x, y, eh, el, ez);
    lat = (o[1] && y == 32'h0) ? 2 : 33;
    @(negedge clk);
    s32.start = 1'b1; s32.op = o; s32.a = x; s32.b = y;
    @(posedge clk); #1;
    s32.start = 1'b0;
    ph = s32.hi; pl = s32.lo;
    chk({tag, " done_pulse"}, 64'(s32.done), 64'(0));
    n = 0;
    while (!s32.done && n < 100) begin
      chk({tag, " busy"}, 64'(s32.busy), 64'(1));
      if (inject && n == 10) begin
        s32.start = 1'b1; s32.op = ~o; s32.a = $urandom; s32.b = $urandom;
      end else s32.start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (!s32.done) chk({tag, " hold"}, {s32.hi, s32.lo}, {ph, pl});
    end
    s32.start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " busy_at_done"}, 64'(s32.busy), 64'(0));
    chk({tag, " result"}, {s32.hi, s32.lo}, {eh, el});
    chk({tag, " dz"}, 64'(s32.div_by_zero), 64'(ez));
  endtask
  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, input string tag);
    logic [7:0] eh, el;
    logic ez;
    int n;
    ref8(o, x, y, eh, el, ez);
    @(negedge clk);
    s8.start = 1'b1; s8.op = o; s8.a = x; s8.b = y;
    @(posedge clk); #1;
    s8.start = 1'b0;
    n = 0;
    while (!s8.done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'((o[1] && y == 8'h0) ? 2 : 9));
    chk({tag, " result"}, 64'({s8.hi, s8.lo}), 64'({eh, el}));
    chk({tag, " dz"}, 64'(s8.div_by_zero), 64'(ez));
  endtask
  initial begin
    logic [1:0] o;
    logic [31:0] x, y;
    bit seen;
    clear = 1'b1;
    s32.start = 1'b0; s32.op = 2'b00; s32.a = '0; s32.b = '0;
    s8.start = 1'b0; s8.op = 2'b00; s8.a = '0; s8.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset32", {s32.busy, s32.done, s32.div_by_zero, s32.hi, s32.lo}, 64'(0));
    chk("reset8", 64'({s8.busy, s8.done, s8.div_by_zero, s8.hi, s8.lo}), 64'(0));
    clear = 1'b0;
    run32(OP_MULS, 32'h12, 32'h14, "muls_small");
    run32(OP_MULS, 32'hFFFFFFFD, 32'h5, "muls_neg");
    run32(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulu_max");
    run32(OP_DIVS, 32'hFFFFFFF9, 32'h2, "divs_neg");
    run32(OP_DIVU, 32'h18, 32'h5, "divu");
    run32(OP_DIVS, 32'h80000000, 32'hFFFFFFFF, "divs_ovf");
    run32(OP_DIVS, 32'h18, 32'h0, "div_zero");
    run32(OP_MULS, 32'h2, 32'h3, "dz_clear");
    run32(OP_DIVU, 32'h7, 32'h0, "divu_zero");
    run32(OP_MULU, $urandom, $urandom, "inject", 1'b1);
    @(negedge clk);
    s32.start = 1'b1; s32.op = OP_MULU; s32.a = $urandom; s32.b = $urandom;
    @(posedge clk); #1;
    s32.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk); #1;
    chk("clear_outputs", {s32.busy, s32.done, s32.div_by_zero, s32.hi, s32.lo}, 64'(0));
    clear = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= s32.done;
    end
    chk("clear_no_done", 64'(seen), 64'(0));
    run32(OP_DIVS, 32'h64, 32'hFFFFFFF9, "after_clear");
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
      run32(o, x, y, "rand32");
    end
    run8(OP_MULS, 8'h80, 8'h80, "w8_muls_min");
    run8(OP_DIVS, 8'h80, 8'hFF, "w8_divs_ovf");
    run8(OP_DIVU, 8'h33, 8'h0, "w8_div_zero");
    for (int i = 0; i < 30; i++)
      run8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 255)), "rand8");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
